// File: rtl/char_write_arbiter_if.sv
// Write-port bundle between the char_buffer requesters and the write arbiter.
// Latency: none (wires only).
// Backpressure: cmd_valid/cmd_ready handshake; fill_req is held until fill_ack.
// Ports:
//   cmd_*   single-cell write request (char, addr, valid) and cmd_ready grant
//   fill_*  run-fill request (char, first addr, count, req, abort) and status
//           (ack pulse, busy level, done pulse)
//   wr_*    registered write port towards char_buffer (char, addr, en)
interface char_write_arbiter_if #(
    parameter int ADDR_BITS = 11
);
    logic [7:0]           cmd_char;
    logic [ADDR_BITS-1:0] cmd_addr;
    logic                 cmd_valid;
    logic                 cmd_ready;

    logic [7:0]           fill_char;
    logic [ADDR_BITS-1:0] fill_addr;
    logic [ADDR_BITS-1:0] fill_count;
    logic                 fill_req;
    logic                 fill_ack;
    logic                 fill_abort;
    logic                 fill_busy;
    logic                 fill_done;

    logic [7:0]           wr_char;
    logic [ADDR_BITS-1:0] wr_addr;
    logic                 wr_en;

    // Arbiter side.
    modport slave (
        input  cmd_char, cmd_addr, cmd_valid,
        output cmd_ready,
        input  fill_char, fill_addr, fill_count, fill_req, fill_abort,
        output fill_ack, fill_busy, fill_done,
        output wr_char, wr_addr, wr_en
    );

    // Requester / buffer side.
    modport master (
        output cmd_char, cmd_addr, cmd_valid,
        input  cmd_ready,
        output fill_char, fill_addr, fill_count, fill_req, fill_abort,
        input  fill_ack, fill_busy, fill_done,
        input  wr_char, wr_addr, wr_en
    );
endinterface

// File: rtl/char_write_arbiter.sv
// Sole write port of char_buffer: merges single-cell cmd writes with a run-fill engine.
// Latency: 1 cycle from accepted request to registered write (wr_en/wr_char/wr_addr).
// Backpressure: cmd_ready low while filling or while a fill is requested; fill wins ties.
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high reset
//   bus    char_write_arbiter_if.slave: cmd request, fill request/status, write port
module char_write_arbiter #(
    parameter int ROWS      = 24,
    parameter int COLS      = 80,
    parameter int ADDR_BITS = 11
) (
    input  logic                 clk,
    input  logic                 reset,
    char_write_arbiter_if.slave  bus
);

    localparam int                   BUF_SIZE   = ROWS * COLS;
    localparam logic [ADDR_BITS-1:0] BUF_SIZE_A = ADDR_BITS'(BUF_SIZE);
    localparam logic [ADDR_BITS-1:0] BUF_LAST_A = ADDR_BITS'(BUF_SIZE - 1);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_BITS-1:0] ptr_q, ptr_d;       // next cell the fill will write
    logic [ADDR_BITS-1:0] rem_q, rem_d;       // writes still owed after the current one
    logic                 wr_en_q, wr_en_d;
    logic [7:0]           wr_char_q, wr_char_d;
    logic [ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
    logic                 ack_q, ack_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [ADDR_BITS-1:0] fill_cnt_clamped;
    logic                 fill_nonzero;

    // Circular-buffer increment: wraps at BUF_SIZE, not at the power of two.
    function automatic logic [ADDR_BITS-1:0] ptr_next(input logic [ADDR_BITS-1:0] p);
        return (p == BUF_LAST_A) ? '0 : p + ADDR_BITS'(1);
    endfunction

    // A count above the buffer size would revisit cells; one pass is enough.
    assign fill_cnt_clamped = (bus.fill_count > BUF_SIZE_A) ? BUF_SIZE_A : bus.fill_count;
    assign fill_nonzero     = (fill_cnt_clamped != '0);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (bus.fill_req && fill_nonzero) state_d = FILL;
            FILL: if (bus.fill_abort || (rem_q == '0)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values. The first fill write is issued on the
    // accept edge so writes occupy exactly the cycles the FSM spends in FILL.
    // wr_char_q doubles as the latched fill character for the whole run.
    always_comb begin
        ptr_d     = ptr_q;
        rem_d     = rem_q;
        wr_en_d   = 1'b0;
        wr_char_d = wr_char_q;
        wr_addr_d = wr_addr_q;
        ack_d     = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.fill_req) begin
                    ack_d     = 1'b1;
                    wr_char_d = bus.fill_char;
                    wr_addr_d = bus.fill_addr;
                    ptr_d     = ptr_next(bus.fill_addr);
                    rem_d     = fill_nonzero ? (fill_cnt_clamped - ADDR_BITS'(1)) : '0;
                    wr_en_d   = fill_nonzero;
                    busy_d    = fill_nonzero;
                    done_d    = ~fill_nonzero;
                end else if (bus.cmd_valid) begin
                    wr_en_d   = 1'b1;
                    wr_char_d = bus.cmd_char;
                    wr_addr_d = bus.cmd_addr;
                end
            end
            FILL: begin
                if (bus.fill_abort || (rem_q == '0)) begin
                    done_d = 1'b1;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = ptr_q;
                    ptr_d     = ptr_next(ptr_q);
                    rem_d     = rem_q - ADDR_BITS'(1);
                    busy_d    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q     <= '0;
            rem_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_char_q <= '0;
            wr_addr_q <= '0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            rem_q     <= rem_d;
            wr_en_q   <= wr_en_d;
            wr_char_q <= wr_char_d;
            wr_addr_q <= wr_addr_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Only unregistered output: a pending fill request blocks cmd in the same cycle.
    assign bus.cmd_ready = (state_q == IDLE) && !bus.fill_req;
    assign bus.fill_ack  = ack_q;
    assign bus.fill_busy = busy_q;
    assign bus.fill_done = done_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_char   = wr_char_q;
    assign bus.wr_addr   = wr_addr_q;

endmodule

// File: tb/tb_char_write_arbiter.sv
// Directed bench for char_write_arbiter: cmd writes, fills, wrap, ties, abort, reset.
// Latency: inputs driven on the falling edge, outputs sampled on the falling edge.
// Backpressure: cmd_ready and fill_ack/fill_done observed against hand-computed cycles.
module tb_char_write_arbiter;

    localparam int AB  = 11;
    localparam int BUF = 1920;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    char_write_arbiter_if #(.ADDR_BITS(AB)) bus();

    char_write_arbiter #(.ROWS(24), .COLS(80), .ADDR_BITS(AB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Per-scenario observation log, cycle 1 = first falling edge after the request.
    int cyc, ack_cyc, done_cyc, last_wr_cyc, done_n, busy_n, rdy_n;
    logic [AB-1:0] wa[$];
    logic [7:0]    wc[$];

    task automatic clear_log();
        cyc = 0; ack_cyc = -1; done_cyc = -1; last_wr_cyc = -1;
        done_n = 0; busy_n = 0; rdy_n = 0;
        wa.delete(); wc.delete();
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (bus.wr_en === 1'b1) begin
            wa.push_back(bus.wr_addr);
            wc.push_back(bus.wr_char);
            last_wr_cyc = cyc;
        end
        if (bus.fill_ack === 1'b1) ack_cyc = cyc;
        if (bus.fill_done === 1'b1) begin done_cyc = cyc; done_n++; end
        if (bus.fill_busy === 1'b1) busy_n++;
        if (bus.cmd_ready === 1'b1) rdy_n++;
    endtask

    task automatic start_fill(input logic [7:0] ch, input int addr, input int count);
        bus.fill_char  = ch;
        bus.fill_addr  = AB'(addr);
        bus.fill_count = AB'(count);
        bus.fill_req   = 1'b1;
    endtask

    task automatic finish_fill(input int budget);
        clear_log();
        step();
        bus.fill_req = 1'b0;
        for (int i = 0; i < budget && done_n == 0; i++) step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.wr_en !== 1'b0) begin n_bad++; $display("FAIL rst_wr_en: got %0h want 0", bus.wr_en); end
        n_cmp++; if (bus.wr_char !== 8'h00) begin n_bad++; $display("FAIL rst_wr_char: got %0h want 0", bus.wr_char); end
        n_cmp++; if (bus.wr_addr !== 11'd0) begin n_bad++; $display("FAIL rst_wr_addr: got %0h want 0", bus.wr_addr); end
        n_cmp++; if (bus.fill_ack !== 1'b0) begin n_bad++; $display("FAIL rst_fill_ack: got %0h want 0", bus.fill_ack); end
        n_cmp++; if (bus.fill_busy !== 1'b0) begin n_bad++; $display("FAIL rst_fill_busy: got %0h want 0", bus.fill_busy); end
        n_cmp++; if (bus.fill_done !== 1'b0) begin n_bad++; $display("FAIL rst_fill_done: got %0h want 0", bus.fill_done); end
        n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rst_cmd_ready: got %0h want 1", bus.cmd_ready); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_cmd_write();
        bus.cmd_char = 8'h41; bus.cmd_addr = 11'd5; bus.cmd_valid = 1'b1;
        #1;
        n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL cmd_ready_idle: got %0h want 1", bus.cmd_ready); end
        clear_log();
        step();
        bus.cmd_valid = 1'b0;
        n_cmp++; if (bus.wr_en !== 1'b1) begin n_bad++; $display("FAIL cmd_wr_en: got %0h want 1", bus.wr_en); end
        n_cmp++; if (bus.wr_char !== 8'h41) begin n_bad++; $display("FAIL cmd_wr_char: got %0h want 41", bus.wr_char); end
        n_cmp++; if (bus.wr_addr !== 11'd5) begin n_bad++; $display("FAIL cmd_wr_addr: got %0d want 5", bus.wr_addr); end
        n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL cmd_ready_after: got %0h want 1", bus.cmd_ready); end
        step();
        n_cmp++; if (wa.size() != 1) begin n_bad++; $display("FAIL cmd_single_write: got %0d writes want 1", wa.size()); end
    endtask

    task automatic test_full_clear();
        int bad;
        start_fill(8'h20, 0, 1920);
        finish_fill(2000);
        bad = 0;
        foreach (wa[i]) if (wa[i] !== AB'(i) || wc[i] !== 8'h20) bad++;
        n_cmp++; if (ack_cyc != 1) begin n_bad++; $display("FAIL full_ack_cycle: got %0d want 1", ack_cyc); end
        n_cmp++; if (wa.size() != 1920) begin n_bad++; $display("FAIL full_write_count: got %0d want 1920", wa.size()); end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL full_addr_data: got %0d bad cells want 0", bad); end
        n_cmp++; if (done_n != 1) begin n_bad++; $display("FAIL full_done_pulses: got %0d want 1", done_n); end
        n_cmp++; if (done_cyc != 1921) begin n_bad++; $display("FAIL full_done_cycle: got %0d want 1921", done_cyc); end
        n_cmp++; if (busy_n != 1920) begin n_bad++; $display("FAIL full_busy_cycles: got %0d want 1920", busy_n); end
        n_cmp++; if (rdy_n != 1) begin n_bad++; $display("FAIL full_cmd_ready_cycles: got %0d want 1", rdy_n); end
    endtask

    task automatic test_wrap();
        int bad;
        start_fill(8'h2E, 1915, 10);
        finish_fill(50);
        bad = 0;
        foreach (wa[i]) if (wa[i] !== AB'((1915 + i) % BUF) || wc[i] !== 8'h2E) bad++;
        n_cmp++; if (wa.size() != 10) begin n_bad++; $display("FAIL wrap_write_count: got %0d want 10", wa.size()); end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL wrap_addr_data: got %0d bad cells want 0", bad); end
        n_cmp++; if (done_cyc != 11) begin n_bad++; $display("FAIL wrap_done_cycle: got %0d want 11", done_cyc); end
    endtask

    task automatic test_collision();
        int bad;
        bus.cmd_char = 8'h55; bus.cmd_addr = 11'd100; bus.cmd_valid = 1'b1;
        start_fill(8'h2D, 10, 3);
        #1;
        n_cmp++; if (bus.cmd_ready !== 1'b0) begin n_bad++; $display("FAIL tie_cmd_ready: got %0h want 0", bus.cmd_ready); end
        finish_fill(20);
        bad = 0;
        foreach (wa[i]) if (wa[i] !== AB'(10 + i) || wc[i] !== 8'h2D) bad++;
        n_cmp++; if (wa.size() != 3) begin n_bad++; $display("FAIL tie_fill_writes: got %0d want 3", wa.size()); end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL tie_fill_addr_data: got %0d bad cells want 0", bad); end
        n_cmp++; if (rdy_n != 1) begin n_bad++; $display("FAIL tie_cmd_ready_cycles: got %0d want 1", rdy_n); end
        n_cmp++; if (done_cyc != 4) begin n_bad++; $display("FAIL tie_done_cycle: got %0d want 4", done_cyc); end
        step();
        bus.cmd_valid = 1'b0;
        n_cmp++; if (wa.size() != 4) begin n_bad++; $display("FAIL tie_cmd_taken: got %0d writes want 4", wa.size()); end
        if (wa.size() >= 4) begin
            n_cmp++; if (wa[3] !== 11'd100 || wc[3] !== 8'h55) begin n_bad++; $display("FAIL tie_cmd_data: got %0h@%0d want 55@100", wc[3], wa[3]); end
        end
        n_cmp++; if (last_wr_cyc != done_cyc + 1) begin n_bad++; $display("FAIL tie_cmd_cycle: got %0d want %0d", last_wr_cyc, done_cyc + 1); end
        step();
        n_cmp++; if (wa.size() != 4) begin n_bad++; $display("FAIL tie_no_dup: got %0d writes want 4", wa.size()); end
    endtask

    task automatic test_count_edges();
        int bad;
        start_fill(8'h33, 50, 0);
        finish_fill(10);
        n_cmp++; if (wa.size() != 0) begin n_bad++; $display("FAIL zero_writes: got %0d want 0", wa.size()); end
        n_cmp++; if (busy_n != 0) begin n_bad++; $display("FAIL zero_busy: got %0d want 0", busy_n); end
        n_cmp++; if (ack_cyc != 1) begin n_bad++; $display("FAIL zero_ack_cycle: got %0d want 1", ack_cyc); end
        n_cmp++; if (done_cyc != 1) begin n_bad++; $display("FAIL zero_done_cycle: got %0d want 1", done_cyc); end
        step();
        n_cmp++; if (done_n != 1) begin n_bad++; $display("FAIL zero_done_pulse: got %0d want 1", done_n); end
        start_fill(8'h2A, 7, 2047);
        finish_fill(2100);
        bad = 0;
        foreach (wa[i]) if (wa[i] !== AB'((7 + i) % BUF) || wc[i] !== 8'h2A) bad++;
        n_cmp++; if (wa.size() != 1920) begin n_bad++; $display("FAIL clamp_write_count: got %0d want 1920", wa.size()); end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL clamp_addr_data: got %0d bad cells want 0", bad); end
        n_cmp++; if (done_cyc != 1921) begin n_bad++; $display("FAIL clamp_done_cycle: got %0d want 1921", done_cyc); end
    endtask

    task automatic test_abort();
        int bad;
        start_fill(8'h58, 160, 80);
        clear_log();
        step();
        bus.fill_req = 1'b0;
        repeat (3) step();
        bus.fill_abort = 1'b1;
        step();
        bus.fill_abort = 1'b0;
        bad = 0;
        foreach (wa[i]) if (wa[i] !== AB'(160 + i)) bad++;
        n_cmp++; if (wa.size() != 4) begin n_bad++; $display("FAIL abort_write_count: got %0d want 4", wa.size()); end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL abort_addrs: got %0d bad cells want 0", bad); end
        n_cmp++; if (done_cyc != 5) begin n_bad++; $display("FAIL abort_done_cycle: got %0d want 5", done_cyc); end
        n_cmp++; if (bus.fill_busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %0h want 0", bus.fill_busy); end
        repeat (3) step();
        n_cmp++; if (wa.size() != 4 || done_n != 1) begin n_bad++; $display("FAIL abort_quiet: got %0d writes %0d dones want 4 1", wa.size(), done_n); end
        // Abort while idle must not block a cmd write.
        bus.fill_abort = 1'b1;
        bus.cmd_char = 8'h7E; bus.cmd_addr = 11'd300; bus.cmd_valid = 1'b1;
        step();
        bus.cmd_valid = 1'b0; bus.fill_abort = 1'b0;
        n_cmp++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 11'd300) begin n_bad++; $display("FAIL abort_idle_cmd: got en %0h @%0d want 1 @300", bus.wr_en, bus.wr_addr); end
        step();
    endtask

    task automatic test_reset_midfill();
        start_fill(8'h4D, 400, 80);
        clear_log();
        step();
        bus.fill_req = 1'b0;
        repeat (2) step();
        n_cmp++; if (bus.wr_en !== 1'b1) begin n_bad++; $display("FAIL midrst_running: got %0h want 1", bus.wr_en); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (bus.wr_en !== 1'b0) begin n_bad++; $display("FAIL midrst_wr_en: got %0h want 0", bus.wr_en); end
        n_cmp++; if (bus.fill_busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %0h want 0", bus.fill_busy); end
        n_cmp++; if (bus.wr_addr !== 11'd0) begin n_bad++; $display("FAIL midrst_wr_addr: got %0d want 0", bus.wr_addr); end
        @(negedge clk);
        reset = 1'b0;
        clear_log();
        repeat (5) step();
        n_cmp++; if (wa.size() != 0 || done_n != 0 || busy_n != 0) begin n_bad++; $display("FAIL midrst_quiet: got %0d writes %0d dones %0d busy want 0 0 0", wa.size(), done_n, busy_n); end
        n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_idle: got cmd_ready %0h want 1", bus.cmd_ready); end
    endtask

    initial begin
        reset          = 1'b1;
        bus.cmd_char   = '0;
        bus.cmd_addr   = '0;
        bus.cmd_valid  = 1'b0;
        bus.fill_char  = '0;
        bus.fill_addr  = '0;
        bus.fill_count = '0;
        bus.fill_req   = 1'b0;
        bus.fill_abort = 1'b0;
        test_reset();
        test_cmd_write();
        test_full_clear();
        test_wrap();
        test_collision();
        test_count_edges();
        test_abort();
        test_reset_midfill();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
